// File: rtl/onehot_result_sel_pkg.sv
// Shared definitions for the ALU result selector: the priority encoder and
// the one-hot legality check. Commands of any width up to MAX_N are handled
// by zero-extending them to MAX_N bits before the call.
package alu_sel_pkg;

  localparam int N_DEFAULT = 6;
  localparam int SEL_W     = $clog2(N_DEFAULT);
  localparam int MAX_N     = 64;
  localparam int IDX_W     = $clog2(MAX_N);

  // Highest set bit among command[MAX_N-1:1]; channel 0 when none is set.
  // Bit 0 never influences the result, so a zero command falls back to 0.
  function automatic logic [IDX_W-1:0] onehot_hi_idx(input logic [MAX_N-1:0] command);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 1; i < MAX_N; i++) begin
      if (command[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // True only when exactly one bit is set.
  function automatic logic is_onehot(input logic [MAX_N-1:0] command);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      if (command[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return seen && !multi;
  endfunction

endpackage

// File: rtl/onehot_result_sel_if.sv
// Bus bundle for the result selector: the input command/result handshake,
// the output result handshake and the error reporting signals.
interface onehot_result_sel_if #(
  parameter int WIDTH = 32,
  parameter int N     = 6,
  parameter int CNT_W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       command;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SW-1:0]      out_sel;
  logic               clear_err;
  logic               illegal_cmd;
  logic [CNT_W-1:0]   illegal_count;

  // Producer/consumer side (drives commands, accepts results).
  modport master (
    output in_valid, command, in_data, out_ready, clear_err,
    input  in_ready, out_valid, out_data, out_sel, illegal_cmd, illegal_count
  );

  // The selector itself.
  modport slave (
    input  in_valid, command, in_data, out_ready, clear_err,
    output in_ready, out_valid, out_data, out_sel, illegal_cmd, illegal_count
  );
endinterface

// File: rtl/onehot_result_sel_skid.sv
// Generic 2-entry valid/ready skid buffer. in_ready comes straight from the
// skid-occupied flop, so there is no combinational path from out_ready.
module result_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] main_data_q, main_data_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          accept;
  logic          drain;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign accept    = in_valid && !skid_valid_q;
  assign drain     = main_valid_q && out_ready;

  // Next-state: skid refills main on a drain; otherwise new data lands in
  // main when it is free (or draining), else parks in skid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      // Both entries full: no accept possible this cycle.
      if (drain) begin
        main_data_d  = skid_data_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || drain) begin
      main_valid_d = accept;
      if (accept) main_data_d = in_data;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // Buffer state; reset discards both entries immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/onehot_result_sel.sv
// Registered one-hot result selector: picks one of N results by the
// hot-line command, buffers {sel, data} through a skid buffer and counts
// accepted malformed commands.
module onehot_result_sel
  import alu_sel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 6,
  parameter int CNT_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  onehot_result_sel_if.slave bus
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [MAX_N-1:0]    cmd_ext;
  logic [SW-1:0]       sel;
  logic                cmd_legal;
  logic [WIDTH-1:0]    chan [N];
  logic [WIDTH-1:0]    sel_data;
  logic [SW+WIDTH-1:0] buf_out;
  logic                accept_in;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // Split the flat result bus into per-channel words.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign chan[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign cmd_ext   = MAX_N'(bus.command);
  assign sel       = SW'(onehot_hi_idx(cmd_ext));
  assign cmd_legal = is_onehot(cmd_ext);
  assign sel_data  = chan[sel];
  assign accept_in = bus.in_valid && bus.in_ready;

  result_skid_buf #(.DW(SW + WIDTH)) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({sel, sel_data}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (buf_out)
  );

  assign {bus.out_sel, bus.out_data} = buf_out;
  assign bus.illegal_cmd   = illegal_q;
  assign bus.illegal_count = count_q;

  // Error tracking: clear first, then a same-cycle malformed accept counts.
  always_comb begin
    illegal_d = illegal_q;
    count_d   = count_q;
    if (bus.clear_err) begin
      illegal_d = 1'b0;
      count_d   = '0;
    end
    if (accept_in && !cmd_legal) begin
      illegal_d = 1'b1;
      if (count_d != '1) count_d = count_d + CNT_W'(1);
    end
  end

  // Sticky flag and saturating counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

endmodule
